div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port aclk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port aresetn, input, 1, synchronous active-low reset, sampled on the aclk rising edge.
REQ-003 SHALL have port flush, input, 1, pipeline flush that abandons the current operation.
REQ-004 SHALL have port start, input, 1, request to begin a division.
REQ-005 SHALL have port aluctrl, input, AluCtrl, operation select; only ALU_DIV, ALU_MOD, ALU_DIVU and ALU_MODU are legal.
REQ-006 SHALL have port src1, input, 32, the dividend.
REQ-007 SHALL have port src2, input, 32, the divisor.
REQ-008 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, 32, the quotient or remainder selected by aluctrl.

Function
REQ-011 SHALL use the states IDLE, CALC, FIX and DONE.
REQ-012 SHALL accept start only in IDLE with flush low; on acceptance it latches aluctrl, |src1|, |src2| and both operand signs, and moves to CALC.
REQ-013 SHALL ignore start while busy, with no effect on the operation in flight.
REQ-014 SHALL perform one restoring step per CALC cycle on a 64-bit remainder/quotient register, using a 6-bit counter, for exactly 32 cycles, then move to FIX.
REQ-015 SHALL, in FIX: negate the quotient when signed and the operand signs differ; negate the remainder when signed and src1 was negative; register result; then move to DONE.
REQ-016 SHALL hold done high for the single DONE cycle, then return to IDLE.
REQ-017 SHALL hold result stable from DONE until the next accepted start.
REQ-018 SHALL have a latency, with start accepted in cycle 0, of CALC in cycles 1-32, FIX in cycle 33 and done in cycle 34.
REQ-019 SHALL produce these results for a zero divisor:
- unsigned: quotient 0xFFFFFFFF, remainder src1;
- signed: quotient 0xFFFFFFFF, sign-fixed per REQ-015 (gives 1 when src1 is negative), remainder src1.
REQ-020 SHALL give quotient 0x80000000 and remainder 0 for signed 0x80000000 / 0xFFFFFFFF.
REQ-021 SHALL, when flush is high in any state, go to IDLE on the next edge; done is not pulsed and result is unchanged.
REQ-022 SHALL give flush priority when flush and start are high in the same cycle; start is not accepted.
REQ-023 SHALL assert done in a DONE cycle even if start is high that cycle; the new start is accepted only in a later IDLE cycle.

Reset
REQ-024 SHALL, while aresetn is low at a clock edge, set the state to IDLE and set busy=0, done=0, result=0, counter=0 and all internal registers to 0, including in the middle of an operation.

Configuration
REQ-025 SHALL, with DIV_FAST_SMALL_EN defined, move directly from IDLE to FIX on an accepted start where |src1| < |src2|, giving quotient 0, remainder src1 and done in cycle 2.
REQ-026 SHALL, without DIV_FAST_SMALL_EN, always take the full 34-cycle path and omit the comparator.

Structure
REQ-027 SHALL place the DivState enum (IDLE, CALC, FIX, DONE) and the constant DIV_ITER=32 in the cpuDefine package; AluCtrl is reused from the same package.
REQ-028 SHALL implement the single restoring iteration as one combinational sub-module, div_step (64-bit in, 32-bit divisor, 64-bit out).

Verification
REQ-029 SHALL cover: ALU_DIV 100/7 -> 14 at cycle 34; ALU_MOD 100/7 -> 2.
REQ-030 SHALL cover: ALU_DIV -7/2 -> 0xFFFFFFFD; ALU_MOD -7/2 -> 0xFFFFFFFF; ALU_DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-031 SHALL cover: ALU_DIVU 0x1234/0 -> 0xFFFFFFFF; ALU_MODU 0x1234/0 -> 0x1234.
REQ-032 SHALL cover: flush in cycle 10 -> busy low from cycle 11, done never pulses, result keeps its prior value; a new start in cycle 11 completes correctly.
REQ-033 SHALL cover: start held high through an operation -> exactly one done, then one new acceptance after IDLE; aresetn low in cycle 5 -> all outputs 0 at the next edge.
REQ-034 SHALL cover: ALU_DIVU 3/5 -> result 0; done at cycle 2 with DIV_FAST_SMALL_EN defined, at cycle 34 without.

Source files
------------

// File: rtl/cpuDefine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpuDefine : shared ALU opcodes, divider state encoding and iteration count
// Rev 1.0
// ---------------------------------------------------------------------------
package cpuDefine;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_MULH = 4'd11,
    ALU_DIV  = 4'd12,
    ALU_MOD  = 4'd13,
    ALU_DIVU = 4'd14,
    ALU_MODU = 4'd15
  } AluCtrl;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } DivState;

  localparam int DIV_ITER = 32;

  function automatic logic is_signed_op(input AluCtrl op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

  function automatic logic is_mod_op(input AluCtrl op);
    return (op == ALU_MOD) || (op == ALU_MODU);
  endfunction

  // Magnitude of a value, treated as two's complement only when sgn is set.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_step : one restoring-division iteration on a {remainder, quotient} pair
// Rev 1.0
// ---------------------------------------------------------------------------
module div_step (
  input  logic [63:0] rq_in,
  input  logic [31:0] divisor,
  output logic [63:0] rq_out
);

  // Shifted partial remainder kept at 33 bits: divisors above 2^31 can push
  // the shifted remainder past 32 bits before the subtract.
  logic [32:0] w_part;
  logic [32:0] w_diff;
  logic        w_ge;

  assign w_part = rq_in[63:31];
  assign w_diff = w_part - {1'b0, divisor};
  assign w_ge   = (w_part >= {1'b0, divisor});

  assign rq_out = w_ge ? {w_diff[31:0], rq_in[30:0], 1'b1}
                       : {rq_in[62:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_unit : 32-bit iterative signed/unsigned divider (quotient or remainder)
// Optional DIV_FAST_SMALL_EN: skip iteration when |src1| < |src2|.  Rev 1.0
// ---------------------------------------------------------------------------
module div_unit
  import cpuDefine::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic        start,
  input  AluCtrl      aluctrl,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  DivState     r_state;
  DivState     w_next;
  AluCtrl      r_op;
  logic        r_sign1;
  logic        r_sign2;
  logic [31:0] r_divisor;
  logic [63:0] r_rq;
  logic [5:0]  r_cnt;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_fast;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [63:0] w_step;
  logic        w_sgn;
  logic [31:0] w_fix_quo;
  logic [31:0] w_fix_rem;
  logic [31:0] w_res;

  assign w_accept = (r_state == IDLE) && start && !flush;
  assign w_abs1   = abs32(src1, is_signed_op(aluctrl));
  assign w_abs2   = abs32(src2, is_signed_op(aluctrl));

`ifdef DIV_FAST_SMALL_EN
  assign w_fast = w_accept && (w_abs1 < w_abs2);
`else
  assign w_fast = 1'b0;
`endif

  div_step u_step (
    .rq_in   (r_rq),
    .divisor (r_divisor),
    .rq_out  (w_step)
  );

  // Sign fix-up: quotient follows the XOR of signs, remainder follows src1.
  assign w_sgn     = is_signed_op(r_op);
  assign w_fix_quo = (w_sgn && (r_sign1 ^ r_sign2)) ? (~r_rq[31:0] + 32'd1) : r_rq[31:0];
  assign w_fix_rem = (w_sgn && r_sign1) ? (~r_rq[63:32] + 32'd1) : r_rq[63:32];
  assign w_res     = is_mod_op(r_op) ? w_fix_rem : w_fix_quo;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next = w_fast ? FIX : CALC;
        CALC:    if (r_cnt == 6'(DIV_ITER - 1)) w_next = FIX;
        FIX:     w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_op      <= ALU_ADD;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_divisor <= 32'd0;
      r_rq      <= 64'd0;
      r_cnt     <= 6'd0;
      r_result  <= 32'd0;
    end else if (w_accept) begin
      r_op      <= aluctrl;
      r_sign1   <= src1[31];
      r_sign2   <= src2[31];
      r_divisor <= w_abs2;
      r_cnt     <= 6'd0;
      // Fast path preloads the answer directly: remainder |src1|, quotient 0.
      r_rq      <= w_fast ? {w_abs1, 32'd0} : {32'd0, w_abs1};
    end else if (!flush && (r_state == CALC)) begin
      r_rq      <= w_step;
      r_cnt     <= r_cnt + 6'd1;
    end else if (!flush && (r_state == FIX)) begin
      r_result  <= w_res;
    end
  end

  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_div_unit : directed vectors plus a cycle-level reference model of div_unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_div_unit;
  import cpuDefine::*;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        flush   = 1'b0;
  logic        start   = 1'b0;
  AluCtrl      aluctrl = ALU_DIV;
  logic [31:0] src1    = 32'd0;
  logic [31:0] src2    = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

`ifdef DIV_FAST_SMALL_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  always #5 aclk = ~aclk;

  div_unit dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .flush   (flush),
    .start   (start),
    .aluctrl (aluctrl),
    .src1    (src1),
    .src2    (src2),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // Arithmetic reference: truncating division, with the zero-divisor results
  // (all-ones quotient sign-fixed, remainder = dividend).
  function automatic logic [31:0] model(input AluCtrl op, input logic [31:0] a, input logic [31:0] b);
    bit     sgn;
    bit     md;
    longint sa;
    longint sb;
    sgn = (op == ALU_DIV) || (op == ALU_MOD);
    md  = (op == ALU_MOD) || (op == ALU_MODU);
    if (b == 32'd0) return md ? a : ((sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF);
    if (!sgn) return md ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return md ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int latency(input AluCtrl op, input logic [31:0] a, input logic [31:0] b);
    bit          sgn;
    logic [31:0] ua;
    logic [31:0] ub;
    sgn = (op == ALU_DIV) || (op == ALU_MOD);
    ua  = (sgn && a[31]) ? (32'd0 - a) : a;
    ub  = (sgn && b[31]) ? (32'd0 - b) : b;
    if (FAST != 0 && ua < ub) return 2;
    return 34;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle model: m_k counts cycles since acceptance (0 = idle); done at m_lat.
  int          m_k    = 0;
  int          m_lat  = 0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] exp_result = 32'd0;

  always @(posedge aclk) begin
    if (!aresetn) begin
      m_k        <= 0;
      m_lat      <= 0;
      exp_result <= 32'd0;
    end else if (flush) begin
      m_k <= 0;
    end else if (m_k == 0) begin
      if (start) begin
        m_k    <= 1;
        m_lat  <= latency(aluctrl, src1, src2);
        m_pend <= model(aluctrl, src1, src2);
      end
    end else if (m_k == m_lat) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_lat) exp_result <= m_pend;
    end
  end

  always @(negedge aclk) begin
    if (chk_en) begin
      check("busy",   {31'd0, busy}, {31'd0, (m_k != 0)});
      check("done",   {31'd0, done}, {31'd0, (m_k != 0) && (m_k == m_lat)});
      check("result", result, exp_result);
      if (done === 1'b1) done_cnt++;
    end
  end

  // Issue one operation from IDLE and check latency and result literally.
  task automatic run_op(input AluCtrl op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc, input string name);
    int cyc;
    bit seen;
    aluctrl = op;
    src1    = a;
    src2    = b;
    start   = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 60 && !seen) begin
      @(negedge aclk);
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge aclk);
        #1;
        cyc++;
      end
    end
    check({name, "_cycle"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
    check({name, "_value"}, result, exp_res);
    @(posedge aclk);
    #1;
  endtask

  int d0;

  initial begin
    repeat (3) @(posedge aclk);
    #1 chk_en = 1'b1;
    @(negedge aclk);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;

    run_op(ALU_DIV,  32'd100,       32'd7,         32'd14,        34, "div_100_7");
    run_op(ALU_MOD,  32'd100,       32'd7,         32'd2,         34, "mod_100_7");
    run_op(ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div_m7_2");
    run_op(ALU_MOD,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "mod_m7_2");
    run_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "div_ovf");
    run_op(ALU_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, "mod_ovf");
    run_op(ALU_DIVU, 32'h1234,      32'd0,         32'hFFFF_FFFF, 34, "divu_by0");
    run_op(ALU_MODU, 32'h1234,      32'd0,         32'h1234,      34, "modu_by0");
    run_op(ALU_DIV,  32'hFFFF_FFFB, 32'd0,         32'd1,         34, "div_neg_by0");
    run_op(ALU_MOD,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 34, "mod_neg_by0");
    run_op(ALU_DIVU, 32'd3,         32'd5,         32'd0,         (FAST != 0) ? 2 : 34, "divu_small");
    run_op(ALU_MOD,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFD, (FAST != 0) ? 2 : 34, "mod_small");
    run_op(ALU_DIVU, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 34, "divu_max_3");
    run_op(ALU_MODU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34, "modu_bigdiv");

    // Flush in cycle 10 of an operation.
    d0      = done_cnt;
    aluctrl = ALU_DIVU;
    src1    = 32'd1000;
    src2    = 32'd3;
    start   = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
    repeat (9) begin
      @(posedge aclk);
      #1;
    end
    flush = 1'b1;
    @(posedge aclk);
    #1 flush = 1'b0;
    @(negedge aclk);
    check("flush_busy",   {31'd0, busy}, 32'd0);
    check("flush_result", result, 32'h7FFF_FFFE);
    check("flush_nodone", 32'(done_cnt), 32'(d0));
    run_op(ALU_DIVU, 32'd1000, 32'd3, 32'd333, 34, "after_flush");
    check("flush_onedone", 32'(done_cnt), 32'(d0 + 1));

    // Start held high across a whole operation: one done, then a re-accept.
    d0      = done_cnt;
    aluctrl = ALU_DIV;
    src1    = 32'hFFFF_FF9C;
    src2    = 32'd7;
    start   = 1'b1;
    repeat (45) @(posedge aclk);
    #1 start = 1'b0;
    check("held_first_done", 32'(done_cnt), 32'(d0 + 1));
    check("held_reaccepted", {31'd0, busy}, 32'd1);
    repeat (40) @(posedge aclk);
    #1;
    check("held_second_done", 32'(done_cnt), 32'(d0 + 2));
    check("held_value", result, 32'hFFFF_FFF2);

    // Reset asserted in cycle 5 of an operation.
    aluctrl = ALU_DIVU;
    src1    = 32'd50;
    src2    = 32'd3;
    start   = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
    repeat (4) begin
      @(posedge aclk);
      #1;
    end
    aresetn = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("midrst_busy",   {31'd0, busy}, 32'd0);
    check("midrst_done",   {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(posedge aclk);
    #1;
    run_op(ALU_MODU, 32'd100, 32'd7, 32'd2, 34, "after_reset");

    repeat (2) @(posedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
